jk_ff_from_sr: RTL and testbench

- JK flip-flop built from an SR flip-flop core plus excitation logic: S = J & ~Q, R = K & Q.
- Generic storage/teaching primitive in the sequential-circuits library.
- Parameterised width, so one instance holds a bank of independent JK bits sharing the clock and reset.
- Excitation logic guarantees S and R are never both 1; this is checked by a diagnostic output.

---
 rtl/seq_pkg.sv | 17 +
 rtl/sr_ff.sv | 51 +++++
 rtl/jk_ff_from_sr.sv | 41 ++++
 tb/tb_jk_ff_from_sr.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared encodings for the sequential-circuits library.
// JK commands and SR commands share the {first, second} bit layout.
package seq_pkg;

  // JK commands, encoded as {j, k}
  localparam logic [1:0] JK_HOLD    = 2'b00;
  localparam logic [1:0] JK_RESET   = 2'b01;
  localparam logic [1:0] JK_SET     = 2'b10;
  localparam logic [1:0] JK_TOGGLE  = 2'b11;

  // SR commands, encoded as {s, r}
  localparam logic [1:0] SR_HOLD    = 2'b00;
  localparam logic [1:0] SR_RESET   = 2'b01;
  localparam logic [1:0] SR_SET     = 2'b10;
  localparam logic [1:0] SR_ILLEGAL = 2'b11;

endpackage : seq_pkg

// File: rtl/sr_ff.sv
// WIDTH-wide bank of independent SR flip-flops with synchronous reset.
// An s=r=1 command leaves the bit unchanged and is flagged in illegal_q.
module sr_ff
  import seq_pkg::*;
#(
  parameter int unsigned          WIDTH     = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] illegal_q
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] illegal_d;

  always_comb begin
    // NOTE: every combinational output gets a default before the case,
    // so no path leaves it unassigned and no latch is inferred.
    q_d       = q_q;
    illegal_d = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      case ({s[i], r[i]})
        SR_HOLD:    q_d[i] = q_q[i];
        SR_RESET:   q_d[i] = 1'b0;
        SR_SET:     q_d[i] = 1'b1;
        SR_ILLEGAL: illegal_d[i] = 1'b1;
        default:    q_d[i] = q_q[i];
      endcase
    end
  end

  // Reset wins outright, so s/r (and any X behind them) are ignored on that edge.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      q_q       <= RESET_VAL;
      illegal_q <= '0;
    end else begin
      q_q       <= q_d;
      illegal_q <= illegal_d;
    end
  end

  assign q = q_q;

endmodule : sr_ff

// File: rtl/jk_ff_from_sr.sv
// Bank of JK flip-flops built from an SR core plus excitation logic.
// s = j & ~q and r = k & q can never both be 1; sr_conflict proves it.
module jk_ff_from_sr
  import seq_pkg::*;
#(
  parameter int unsigned          WIDTH     = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             sr_conflict
);

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] illegal_q;

  // Set only bits that are low, reset only bits that are high: j=k=1 toggles.
  assign s = j & ~q;
  assign r = k &  q;

  sr_ff #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_sr_ff (
    .clk       (clk),
    .rst       (rst),
    .s         (s),
    .r         (r),
    .q         (q),
    .illegal_q (illegal_q)
  );

  assign q_n         = ~q;
  assign sr_conflict = |illegal_q;

endmodule : jk_ff_from_sr

// File: tb/tb_jk_ff_from_sr.sv
// Directed bench for jk_ff_from_sr: literal per-edge expectations plus a
// JK-table model compared against both instances on every falling edge.
module tb_jk_ff_from_sr;
  import seq_pkg::*;

  localparam int         W   = 4;
  localparam logic [W-1:0] RV2 = 4'b0101;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] j, k;
  logic [W-1:0] q_a, q_n_a, q_b, q_n_b;
  logic         conf_a, conf_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  jk_ff_from_sr #(.WIDTH(W), .RESET_VAL('0)) u_dut (
    .clk(clk), .rst(rst), .j(j), .k(k),
    .q(q_a), .q_n(q_n_a), .sr_conflict(conf_a)
  );

  jk_ff_from_sr #(.WIDTH(W), .RESET_VAL(RV2)) u_dut_rv (
    .clk(clk), .rst(rst), .j(j), .k(k),
    .q(q_b), .q_n(q_n_b), .sr_conflict(conf_b)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the JK truth table applied bit by bit.
  function automatic logic [W-1:0] jk_next(input logic [W-1:0] cur,
                                           input logic [W-1:0] jv,
                                           input logic [W-1:0] kv);
    logic [W-1:0] nxt;
    for (int i = 0; i < W; i++) begin
      case ({jv[i], kv[i]})
        JK_HOLD:   nxt[i] = cur[i];
        JK_RESET:  nxt[i] = 1'b0;
        JK_SET:    nxt[i] = 1'b1;
        default:   nxt[i] = ~cur[i];
      endcase
    end
    return nxt;
  endfunction

  logic [W-1:0] m_a, m_b;
  logic         m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_a     <= '0;
      m_b     <= RV2;
      m_valid <= 1'b1;
    end else if (m_valid) begin
      m_a <= jk_next(m_a, j, k);
      m_b <= jk_next(m_b, j, k);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_q",     q_a,    m_a);
      check("model_q_n",   q_n_a,  ~m_a);
      check("model_conf",  {3'b0, conf_a}, 4'b0);
      check("model_rv_q",  q_b,    m_b);
      check("model_rv_qn", q_n_b,  ~m_b);
      check("model_rv_cf", {3'b0, conf_b}, 4'b0);
    end
  end

  task automatic drive(input logic [W-1:0] jv, input logic [W-1:0] kv, input logic rv);
    j   = jv;
    k   = kv;
    rst = rv;
  endtask

  task automatic edge_check(input string name, input logic [W-1:0] exp);
    @(posedge clk);
    #2;
    check(name, q_a, exp);
    check({name, "_conf"}, {3'b0, conf_a}, 4'b0);
  endtask

  localparam logic [W-1:0] Z = 4'b0000;
  localparam logic [W-1:0] F = 4'b1111;

  initial begin
    drive(Z, Z, 1'b1);

    // Reset, then K alone keeps q low
    edge_check("reset_q", Z);
    check("reset_q_n", q_n_a, F);
    check("reset_rv_q", q_b, RV2);
    check("reset_rv_q_n", q_n_b, ~RV2);
    drive(Z, F, 1'b0); edge_check("k_from_0", Z);

    // Set and hold
    drive(F, Z, 1'b0); edge_check("set", F);
    drive(Z, Z, 1'b0); edge_check("hold_1", F);

    // Toggle held over several edges
    drive(F, F, 1'b0); edge_check("toggle_1", Z);
    edge_check("toggle_2", F);
    edge_check("toggle_3", Z);
    edge_check("toggle_4", F);

    // Reset/set sequence after a reset
    drive(Z, Z, 1'b1); edge_check("seq_reset", Z);
    drive(Z, F, 1'b0); edge_check("seq_01a", Z);
    drive(Z, Z, 1'b0); edge_check("seq_00a", Z);
    drive(F, Z, 1'b0); edge_check("seq_10a", F);
    drive(Z, Z, 1'b0); edge_check("seq_00b", F);
    drive(F, F, 1'b0); edge_check("seq_11",  Z);
    drive(Z, Z, 1'b0); edge_check("seq_00c", Z);
    drive(Z, F, 1'b0); edge_check("seq_01b", Z);
    drive(Z, Z, 1'b0); edge_check("seq_00d", Z);
    drive(F, Z, 1'b0); edge_check("seq_10b", F);
    drive(Z, Z, 1'b0); edge_check("seq_00e", F);

    // Synchronous reset beats a pending toggle
    drive(F, F, 1'b1);
    #1 check("rst_not_async", q_a, F);
    edge_check("rst_over_toggle", Z);
    check("rst_rv_over_toggle", q_b, RV2);
    drive(F, F, 1'b0); edge_check("after_rst_toggle", F);

    // Mixed per-bit commands from q=0011
    drive(Z, 4'b1100, 1'b0); edge_check("mixed_prep", 4'b0011);
    drive(4'b1010, 4'b0110, 1'b0); edge_check("mixed", 4'b1001);

    // X on j/k while in reset must not leak into q
    drive('x, 'x, 1'b1); edge_check("x_in_reset", Z);
    check("x_in_reset_rv", q_b, RV2);
    drive(Z, Z, 1'b0); edge_check("x_after", Z);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_jk_ff_from_sr
